// File: rtl/snn_layer_sched.sv
// Time-multiplexed scheduler for one fully-connected SNN layer: a shared 5-input
// spike MAC is walked across all neurons each timestep, with leaky integrate-and-fire.
module snn_layer_sched #(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned ADDR_W      = 4,
  parameter logic [7:0]  THRESH      = 8'd100,
  parameter logic [7:0]  LEAK        = 8'd1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [4:0]             pixels_in,
  output logic [ADDR_W-1:0]      weight_addr,
  input  logic [39:0]            weight_rdata,
  output logic [4:0]             mac_pixels,
  output logic [39:0]            mac_weights,
  input  logic [7:0]             mac_sum,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] spikes_out
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACC, S_DONE} state_t;

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_cnt;
  logic [ADDR_W-1:0]      r_addr;
  logic [4:0]             r_pix;
  logic                   r_busy;
  logic                   r_done;
  logic [NUM_NEURONS-1:0] r_spikes;
  logic [7:0]             r_v [NUM_NEURONS];

  logic [8:0] w_sum;
  logic [7:0] w_sat;
  logic [7:0] w_leaked;
  logic       w_fire;
  logic       w_last;

  // 9-bit add so the carry drives saturation; mac_sum itself is taken as-is (already wrapped).
  always_comb begin
    w_sum    = {1'b0, r_v[r_cnt]} + {1'b0, mac_sum};
    w_sat    = w_sum[8] ? 8'hFF : w_sum[7:0];
    w_leaked = (w_sat >= LEAK) ? (w_sat - LEAK) : '0;
    w_fire   = (w_leaked >= THRESH);
    w_last   = (r_cnt == ADDR_W'(NUM_NEURONS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_pix    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_spikes <= '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) r_v[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) r_v[i] <= '0;
          end
          if (start) begin
            r_pix    <= pixels_in;
            r_spikes <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_ACC;
        S_ACC: begin
          if (w_fire) begin
            r_spikes[r_cnt] <= 1'b1;
            r_v[r_cnt]      <= '0;
          end else begin
            r_v[r_cnt] <= w_leaked;
          end
          // Address advances with the counter so it is already stable throughout FETCH.
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_addr  <= r_cnt + 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign weight_addr = r_addr;
  assign mac_pixels  = r_pix;
  assign mac_weights = weight_rdata;
  assign busy        = r_busy;
  assign done        = r_done;
  assign spikes_out  = r_spikes;

endmodule

// File: tb/tb_snn_layer_sched.sv
// Scoreboard bench for snn_layer_sched: a 10-neuron instance (THRESH 100) and a
// 2-neuron instance (THRESH 255) with behavioural weight memory and spike MAC.
module tb_snn_layer_sched;

  typedef struct {
    logic [15:0] sp;
    int          acc;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        start_a, clear_a, start_b, clear_b;
  logic [4:0]  pix_a, pix_b, mp_a, mp_b;
  logic [3:0]  addr_a;
  logic [0:0]  addr_b;
  logic [39:0] rdata_a, rdata_b, mw_a, mw_b;
  logic [7:0]  sum_a, sum_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [9:0]  spikes_a;
  logic [1:0]  spikes_b;

  logic [39:0] wm [2][16];
  int          mv [2][16];
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        ea, eb;

  function automatic logic [7:0] mac_model(input logic [4:0] p, input logic [39:0] w);
    int acc;
    acc = 0;
    for (int i = 0; i < 5; i++) if (p[i]) acc += int'(w[8*i +: 8]);
    return 8'(acc);
  endfunction

  assign sum_a = mac_model(mp_a, mw_a);
  assign sum_b = mac_model(mp_b, mw_b);

  always @(posedge clk) begin
    rdata_a <= wm[0][addr_a];
    rdata_b <= wm[1][addr_b];
  end

  snn_layer_sched #(.NUM_NEURONS(10), .ADDR_W(4), .THRESH(8'd100), .LEAK(8'd1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .clear(clear_a), .pixels_in(pix_a),
    .weight_addr(addr_a), .weight_rdata(rdata_a), .mac_pixels(mp_a), .mac_weights(mw_a),
    .mac_sum(sum_a), .busy(busy_a), .done(done_a), .spikes_out(spikes_a));

  snn_layer_sched #(.NUM_NEURONS(2), .ADDR_W(1), .THRESH(8'd255), .LEAK(8'd1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .clear(clear_b), .pixels_in(pix_b),
    .weight_addr(addr_b), .weight_rdata(rdata_b), .mac_pixels(mp_b), .mac_weights(mw_b),
    .mac_sum(sum_b), .busy(busy_b), .done(done_b), .spikes_out(spikes_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (done_a) begin
      chk("busy_low_at_done_a", int'(busy_a), 0);
      if (q0.size() == 0) chk("unexpected_done_a", 1, 0);
      else begin
        ea = q0.pop_front();
        chk("spikes_a", int'(spikes_a), int'(ea.sp[9:0]));
        chk("latency_a", cyc - ea.acc, ea.lat);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (done_b) begin
      if (q1.size() == 0) chk("unexpected_done_b", 1, 0);
      else begin
        eb = q1.pop_front();
        chk("spikes_b", int'(spikes_b), int'(eb.sp[1:0]));
        chk("latency_b", cyc - eb.acc, eb.lat);
      end
    end
  end

  task automatic model_ts(input int d, input logic [4:0] pix, input bit clr,
                          output logic [15:0] sp);
    int nn, thr, s;
    nn  = (d == 0) ? 10 : 2;
    thr = (d == 0) ? 100 : 255;
    sp  = '0;
    if (clr) for (int n = 0; n < 16; n++) mv[d][n] = 0;
    for (int n = 0; n < nn; n++) begin
      s = mv[d][n] + int'(mac_model(pix, wm[d][n]));
      if (s > 255) s = 255;
      s = s - 1;
      if (s < 0) s = 0;
      if (s >= thr) begin
        sp[n] = 1'b1;
        mv[d][n] = 0;
      end else begin
        mv[d][n] = s;
      end
    end
  endtask

  task automatic drive(input int d, input logic s, input logic c, input logic [4:0] p);
    if (d == 0) begin start_a = s; clear_a = c; pix_a = p; end
    else        begin start_b = s; clear_b = c; pix_b = p; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_spikes"}, int'(spikes_a), 0);
    chk({tag, "_addr"}, int'(addr_a), 0);
    chk({tag, "_mac_pixels"}, int'(mp_a), 0);
  endtask

  // One timestep; the *_at arguments are cycles after acceptance (0 = unused).
  task automatic run_ts(input int d, input logic [4:0] pix, input bit clr,
                        input int start_at, input int clear_at, input int tog_at,
                        input int rst_at);
    exp_t        e;
    logic [15:0] sp;
    bit          seen;
    @(posedge clk); #1;
    if (rst_at == 0) begin
      model_ts(d, pix, clr, sp);
      e.sp  = sp;
      e.acc = cyc + 1;
      e.lat = (d == 0) ? 21 : 5;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    drive(d, 1'b1, clr, pix);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, pix);
    seen = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(posedge clk); #1;
      if ((d == 0) ? done_a : done_b) seen = 1;
      else begin
        if (c == 1) chk("busy_during_run", int'((d == 0) ? busy_a : busy_b), 1);
        drive(d, c == start_at, c == clear_at,
              (tog_at > 0 && c >= tog_at) ? (pix ^ 5'(c)) : pix);
        if (d == 0 && tog_at > 0 && c == tog_at + 2) chk("mac_pixels_latched", int'(mp_a), int'(pix));
        if (c == rst_at) begin
          #3 rst_n = 1'b0;
          #1 check_reset_outputs("midrun_reset");
          for (int k = 0; k < 2; k++) for (int n = 0; n < 16; n++) mv[k][n] = 0;
          drive(d, 1'b0, 1'b0, pix);
          #2 rst_n = 1'b1;
          return;
        end
      end
    end
    drive(d, 1'b0, 1'b0, pix);
    if (!seen) begin
      chk("done_timeout", 0, 1);
      if (d == 0 && q0.size() > 0) void'(q0.pop_front());
      if (d == 1 && q1.size() > 0) void'(q1.pop_front());
    end
  endtask

  task automatic set_w(input int d, input logic [39:0] w);
    for (int n = 0; n < 16; n++) wm[d][n] = w;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) for (int n = 0; n < 16; n++) begin wm[k][n] = '0; mv[k][n] = 0; end
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 5'b0);
    drive(1, 1'b0, 1'b0, 5'b0);
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    #4 rst_n = 1'b1;
    @(posedge clk); #1 check_reset_outputs("post_reset");

    // Saturation with THRESH 255: preload 200, then 200+100 -> 255 -> 254, no spike.
    set_w(1, {32'h0, 8'd201});
    run_ts(1, 5'b00001, 1'b0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    for (int n = 0; n < 2; n++) chk("v_b_preload", int'(u_dut_b.r_v[n]), mv[1][n]);
    set_w(1, {32'h0, 8'd100});
    run_ts(1, 5'b00001, 1'b0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    for (int n = 0; n < 2; n++) chk("v_b_saturated", int'(u_dut_b.r_v[n]), mv[1][n]);

    // Uniform drive, sum 50: 49, 98, then fire all.
    set_w(0, {5{8'd10}});
    repeat (3) run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 0);

    // Wrap: 5*100 = 500 -> 244 -> 243, fire all.
    set_w(0, {5{8'd100}});
    run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 chk("spikes_hold_after_done", int'(spikes_a), 10'h3FF);

    // Saturation at THRESH 100: 98 + 244 must saturate (fire), not wrap to 85.
    set_w(0, {5{8'd10}});
    repeat (2) run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 0);
    set_w(0, {5{8'd100}});
    run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 0);

    // Sparse input with pixels_in toggling mid-run; then probe V[n] = n-1 exactly.
    for (int n = 0; n < 16; n++) wm[0][n] = {32'hFFFF_FFFF, 8'(n)};
    run_ts(0, 5'b00001, 1'b0, 0, 0, 6, 0);
    for (int n = 0; n < 16; n++) wm[0][n] = {32'hFFFF_FFFF, 8'(102 - n)};
    run_ts(0, 5'b00001, 1'b0, 0, 0, 0, 0);

    // start at cycle 5 and clear at cycle 7 while busy must be ignored.
    set_w(0, {5{8'd10}});
    run_ts(0, 5'b11111, 1'b0, 5, 7, 0, 0);
    run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 0);
    run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 0);

    // Reset at cycle 9 of a run discards partial potentials.
    run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 0);
    run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 9);
    @(posedge clk); #1 check_reset_outputs("after_midrun_reset");
    run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 0);
    run_ts(0, 5'b11111, 1'b0, 0, 0, 0, 0);

    // clear + start together: V=90 then sum 20 gives 19, not 109; then 19+82-1 = 100 fires.
    set_w(0, {32'hFFFF_FFFF, 8'd91});
    run_ts(0, 5'b00001, 1'b1, 0, 0, 0, 0);
    set_w(0, {32'hFFFF_FFFF, 8'd20});
    run_ts(0, 5'b00001, 1'b1, 0, 0, 0, 0);
    set_w(0, {32'hFFFF_FFFF, 8'd82});
    run_ts(0, 5'b00001, 1'b0, 0, 0, 0, 0);

    repeat (5) @(posedge clk);
    #1 chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_layer_sched.md
Name: snn_layer_sched

Overview:
- Time-multiplexes one shared 5-input spike MAC (5 spike bits × 5 packed 8-bit weights -> 8-bit sum) across NUM_NEURONS output neurons of one fully-connected SNN layer.
- Per timestep it:
  - latches the 5-bit input spike vector;
  - walks every neuron, fetching that neuron's 40-bit weight word from synchronous weight memory;
  - drives the MAC and integrates the sum into the neuron's membrane potential with leak;
  - fires and resets neurons that reach threshold, then reports the layer spike vector.

Parameters:
- NUM_NEURONS, 10, neurons scheduled per timestep (2..16)
- ADDR_W, 4, weight memory address width; 2^ADDR_W >= NUM_NEURONS
- THRESH, 100, firing threshold, unsigned 8-bit
- LEAK, 1, per-timestep leak subtracted after integration, unsigned 8-bit

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin one timestep; honoured only in IDLE
- clear  input  1  zero all membrane potentials; honoured only in IDLE
- pixels_in  input  5  input spike vector, sampled when start is accepted
- weight_addr  output  ADDR_W  weight memory read address (neuron index)
- weight_rdata  input  40  weight word; valid the cycle after weight_addr is presented
- mac_pixels  output  5  spike vector to the shared MAC
- mac_weights  output  40  weight word to the shared MAC
- mac_sum  input  8  combinational MAC result
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse, timestep complete
- spikes_out  output  NUM_NEURONS  bit n = neuron n fired this timestep

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; busy=0, done=0, spikes_out=0, weight_addr=0, mac_pixels=0;
  - all potentials V[n]=0, neuron counter=0.
- FSM: IDLE -> FETCH -> ACC -> (FETCH | DONE) -> IDLE.
- IDLE:
  - start=1 -> latch pixels_in into a register driving mac_pixels; clear spikes_out; counter=0; busy=1; go FETCH.
  - clear=1 -> all V[n]=0 at that edge.
  - clear and start together -> both act: potentials zeroed, timestep starts from zero.
- FETCH: weight_addr=counter; go ACC.
- ACC:
  - mac_weights=weight_rdata (combinational pass-through).
  - At the edge, with s = V[counter] + mac_sum as a 9-bit value:
    - sat = min(s, 255);
    - v = sat - LEAK, floored at 0;
    - if v >= THRESH: spikes_out[counter]=1 and V[counter]=0; else V[counter]=v.
  - counter == NUM_NEURONS-1 -> DONE; else counter+1, go FETCH.
- DONE: done=1 for exactly this cycle; busy=0 at the exit edge; go IDLE.
- Latency: start accepted at edge k -> done high in the cycle after edge k+2·NUM_NEURONS+1 (default 21 edges). Throughput is one neuron per 2 cycles.
- mac_sum is 8-bit modulo (the MAC wraps). The scheduler treats it as unsigned and never widens it.
- start or clear while busy: ignored, no effect on the current timestep.
- spikes_out holds its value after done until the next accepted start.
- mac_pixels holds the latched vector for the whole timestep; a pixels_in change mid-run has no effect.
- rst_n asserted mid-timestep: immediate return to IDLE with all reset values. No done pulse; partial potentials discarded.
- weight_addr outside FETCH/ACC: holds last value; memory reads there are don't-care.

Test Plan:
- All 10 weight words = {5{8'd10}}, pixels_in=5'b11111 (mac_sum=50), three timesteps:
  - V[n] = 49 after timestep 1, 98 after timestep 2;
  - timestep 3 yields 147 >= 100 -> spikes_out=10'h3FF and V=0;
  - done exactly 21 cycles after each start.
- Wrap and saturation:
  - weights {5{8'd100}}, pixels=5'b11111 -> mac_sum=244 (wrapped); timestep 1 -> V=243, spike;
  - preload V=200 via sum 201 with THRESH raised to 255 -> next sum saturates to 255 -> 254, no spike.
- Sparse input, pixels=5'b00001, weight word n low byte = n: V[n] = max(n-1, 0); spikes_out=0; mac_pixels stays 5'b00001 even when pixels_in toggles mid-run.
- start pulsed again at cycle 5 of a run, and clear at cycle 7: both ignored; done still at 21; potentials unchanged by clear.
- rst_n dropped at cycle 9 of a run -> outputs and potentials 0 asynchronously; a new start then completes normally from V=0.
- clear and start in the same IDLE cycle with V[n]=90 and mac_sum=20 -> V=19, not 109; spikes_out=0.
